instr_encoder: RTL and testbench

//   Packs RV32 instruction fields (opcode, rd, rs1, rs2, funct3, funct7, signed immediate)

---
 rtl/instr_encoder.sv | 150 +++++++++++++++
 tb/tb_instr_encoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32 field-to-word encoder for R/I/S/SB formats, feeding instruction memory through
// one registered output stage with backpressure and an auto-incrementing word address.
module instr_encoder #(
    parameter int ADDR_W   = 5,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          in_opcode,
    input  logic [4:0]          in_rd,
    input  logic [4:0]          in_rs1,
    input  logic [4:0]          in_rs2,
    input  logic [2:0]          in_funct3,
    input  logic [6:0]          in_funct7,
    input  logic [31:0]         in_imm,
    output logic                mem_we,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                wrap,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_SB = 7'b1100011;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  wrap_q, wrap_d;
    logic                  err_q, err_d;
    logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic signed [31:0]    imm_s;
    logic                  imm12_ok;
    logic                  imm_sb_ok;
    logic                  enc_ok;
    logic [31:0]           enc_word;
    logic                  accept;
    logic                  write;

    assign imm_s     = in_imm;
    assign imm12_ok  = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign imm_sb_ok = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];

    // Reset also gates ready so nothing can be offered while the stage is being cleared.
    assign in_ready = rst_n && !clr && ((state_q == EMPTY) || mem_ready);
    assign accept   = in_valid && in_ready;
    assign write    = (state_q == FULL) && mem_ready;

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b0;
        case (in_opcode)
            OP_R: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_ok   = 1'b1;
            end
            OP_I: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_ok   = imm12_ok;
            end
            OP_S: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_ok   = imm12_ok;
            end
            OP_SB: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                enc_ok   = imm_sb_ok;
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // A write retires the current word; a good accept in the same edge refills without a bubble.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wrap_d      = wrap_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;

        if (clr) begin
            state_d     = EMPTY;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            wrap_d      = 1'b0;
            err_d       = 1'b0;
            err_cnt_d   = '0;
        end else begin
            if (write) begin
                state_d    = EMPTY;
                mem_addr_d = mem_addr_q + ADDR_W'(1);
                if (mem_addr_q == '1) begin
                    wrap_d = 1'b1;
                end
            end
            if (accept) begin
                if (enc_ok) begin
                    state_d     = FULL;
                    mem_wdata_d = enc_word;
                end else begin
                    err_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERRCNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign mem_we    = (state_q == FULL);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wrap      = wrap_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected words and addresses go into a scoreboard queue
// at accept time and are compared when the DUT presents a write that IMEM takes.
module tb_instr_encoder;

    localparam int ADDR_W   = 5;
    localparam int ERRCNT_W = 8;
    localparam int DEPTH    = 1 << ADDR_W;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_SB = 7'b1100011;

    logic                clk;
    logic                rst_n;
    logic                clr;
    logic                in_valid;
    logic                in_ready;
    logic [6:0]          in_opcode;
    logic [4:0]          in_rd;
    logic [4:0]          in_rs1;
    logic [4:0]          in_rs2;
    logic [2:0]          in_funct3;
    logic [6:0]          in_funct7;
    logic [31:0]         in_imm;
    logic                mem_we;
    logic                mem_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_wdata;
    logic                wrap;
    logic                err;
    logic [ERRCNT_W-1:0] err_cnt;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_addr = 0;
    int          exp_err_cnt = 0;
    int          waited;
    logic [31:0] held_word;
    logic [31:0] rnd_word;

    instr_encoder #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .wrap(wrap), .err(err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any miss on one line.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rModel(input logic [6:0] f7, input logic [4:0] rs2,
                                            input logic [4:0] rs1, input logic [2:0] f3,
                                            input logic [4:0] rd);
        return (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
               (32'(f3) << 12) | (32'(rd) << 7) | 32'(OP_R);
    endfunction

    // Drives one bundle and holds it until accepted; good bundles queue their expected write.
    task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm, input logic good, input logic [31:0] word,
                                 output int n_wait);
        sb_entry_t e;
        in_opcode = op;  in_rd = rd;  in_rs1 = rs1;  in_rs2 = rs2;
        in_funct3 = f3;  in_funct7 = f7;  in_imm = imm;  in_valid = 1'b1;
        n_wait = 0;
        @(negedge clk);
        while (!in_ready && n_wait < 50) begin
            n_wait++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $error("[TB] FAIL accept_timeout observed=in_ready_low expected=accept_within_50");
        end else if (good) begin
            e.addr = ADDR_W'(exp_addr);
            e.data = word;
            sb.push_back(e);
            exp_addr = (exp_addr + 1) % DEPTH;
        end else if (exp_err_cnt < 255) begin
            exp_err_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Write monitor: whatever IMEM takes must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && !clr && mem_we && mem_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_write", {31'b0, mem_we}, 32'h0);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                checkOutput("wr_data", mem_wdata, e.data);
                checkOutput("wr_addr", 32'(mem_addr), 32'(e.addr));
            end
        end
    end

    initial begin
        rst_n = 1'b0;  clr = 1'b0;  mem_ready = 1'b1;  in_valid = 1'b0;
        in_opcode = '0;  in_rd = '0;  in_rs1 = '0;  in_rs2 = '0;
        in_funct3 = '0;  in_funct7 = '0;  in_imm = '0;
        #2;
        checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rst_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_wdata", mem_wdata, 32'h0);
        checkOutput("rst_wrap", 32'(wrap), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Four back-to-back instructions, none of them may wait
        applyStimulus(OP_I, 5, 2, 0, 3'b010, 0, -32'sd4, 1'b1, 32'hFFC12283, waited);
        applyStimulus(OP_S, 0, 2, 6, 3'b010, 0, 32'd8, 1'b1, 32'h00612423, waited);
        checkOutput("b2b_wait_s", 32'(waited), 32'h0);
        applyStimulus(OP_SB, 0, 1, 2, 3'b000, 0, -32'sd8, 1'b1, 32'hFE208CE3, waited);
        checkOutput("b2b_wait_sb", 32'(waited), 32'h0);
        applyStimulus(OP_R, 3, 1, 2, 3'b000, 7'h00, 32'h0, 1'b1, 32'h002081B3, waited);
        checkOutput("b2b_wait_r", 32'(waited), 32'h0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("drain_we", 32'(mem_we), 32'h0);
        checkOutput("drain_addr", 32'(mem_addr), 32'd4);

        // Ignored fields must not leak into the word; immediate range boundaries that pass
        applyStimulus(OP_R, 3, 1, 2, 3'b000, 7'h00, 32'hDEADBEEF, 1'b1, 32'h002081B3, waited);
        applyStimulus(OP_I, 5, 2, 31, 3'b010, 7'h7F, -32'sd4, 1'b1, 32'hFFC12283, waited);
        applyStimulus(OP_S, 31, 2, 6, 3'b010, 7'h7F, 32'd8, 1'b1, 32'h00612423, waited);
        applyStimulus(OP_I, 1, 0, 0, 3'b010, 0, 32'd2047, 1'b1, 32'h7FF02083, waited);
        applyStimulus(OP_I, 1, 0, 0, 3'b010, 0, -32'sd2048, 1'b1, 32'h80002083, waited);
        applyStimulus(OP_SB, 0, 0, 0, 3'b000, 0, 32'd4094, 1'b1, 32'h7E000FE3, waited);
        applyStimulus(OP_SB, 0, 0, 0, 3'b000, 0, -32'sd4096, 1'b1, 32'h80000063, waited);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Rejected bundles: consumed, dropped, counted
        applyStimulus(OP_I, 1, 0, 0, 3'b000, 0, 32'd2048, 1'b0, 32'h0, waited);
        applyStimulus(OP_SB, 0, 1, 2, 3'b000, 0, 32'd3, 1'b0, 32'h0, waited);
        applyStimulus(7'b0110111, 1, 0, 0, 3'b000, 0, 32'h0, 1'b0, 32'h0, waited);
        idle();
        @(posedge clk); #1;
        checkOutput("drop_err", 32'(err), 32'h1);
        checkOutput("drop_err_cnt", 32'(err_cnt), 32'd3);
        checkOutput("drop_we", 32'(mem_we), 32'h0);
        checkOutput("drop_addr", 32'(mem_addr), 32'(exp_addr));
        applyStimulus(OP_S, 0, 0, 0, 3'b000, 0, -32'sd2049, 1'b0, 32'h0, waited);
        applyStimulus(OP_SB, 0, 0, 0, 3'b000, 0, 32'd4096, 1'b0, 32'h0, waited);
        applyStimulus(OP_SB, 0, 0, 0, 3'b000, 0, -32'sd4098, 1'b0, 32'h0, waited);
        idle();
        @(posedge clk); #1;
        checkOutput("drop_err_cnt6", 32'(err_cnt), 32'(exp_err_cnt));
        checkOutput("drop_addr6", 32'(mem_addr), 32'(exp_addr));

        // Backpressure: word held stable, input stalled, one write on release
        mem_ready = 1'b0;
        held_word = rModel(7'h20, 5'd7, 5'd8, 3'b000, 5'd9);
        applyStimulus(OP_R, 9, 8, 7, 3'b000, 7'h20, 32'h0, 1'b1, held_word, waited);
        in_opcode = OP_R;  in_rd = 5'd10;  in_funct7 = 7'h00;  in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("stall_in_ready", 32'(in_ready), 32'h0);
            checkOutput("stall_wdata", mem_wdata, held_word);
            checkOutput("stall_addr", 32'(mem_addr), 32'((exp_addr + DEPTH - 1) % DEPTH));
        end
        mem_ready = 1'b1;
        applyStimulus(OP_R, 10, 8, 7, 3'b000, 7'h00, 32'h0, 1'b1, rModel(7'h00, 5'd7, 5'd8, 3'b000, 5'd10), waited);
        checkOutput("release_wait", 32'(waited), 32'h0);

        // Write coinciding with a dropped accept empties the stage
        applyStimulus(OP_I, 1, 0, 0, 3'b000, 0, -32'sd2049, 1'b0, 32'h0, waited);
        idle();
        #1;
        checkOutput("wdrop_we", 32'(mem_we), 32'h0);
        checkOutput("wdrop_addr", 32'(mem_addr), 32'(exp_addr));
        checkOutput("wdrop_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));

        // Error counter saturates
        repeat (260) applyStimulus(7'h7F, 0, 0, 0, 3'b000, 0, 32'h0, 1'b0, 32'h0, waited);
        idle();
        @(posedge clk); #1;
        checkOutput("sat_err_cnt", 32'(err_cnt), 32'd255);

        // CLR discards a pending word even with IMEM ready
        applyStimulus(OP_R, 1, 1, 1, 3'b000, 0, 32'h0, 1'b1, rModel(7'h00, 5'd1, 5'd1, 3'b000, 5'd1), waited);
        idle();
        clr = 1'b1;
        #1;
        checkOutput("clr_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        clr = 1'b0;
        void'(sb.pop_back());
        exp_addr = 0;
        exp_err_cnt = 0;
        checkOutput("clr_we", 32'(mem_we), 32'h0);
        checkOutput("clr_addr", 32'(mem_addr), 32'h0);
        checkOutput("clr_wrap", 32'(wrap), 32'h0);
        checkOutput("clr_err", 32'(err), 32'h0);
        checkOutput("clr_err_cnt", 32'(err_cnt), 32'h0);

        // Address wrap over the full depth plus one
        for (int i = 0; i <= DEPTH; i++) begin
            logic [4:0] rd;
            logic [4:0] rs1;
            logic [4:0] rs2;
            logic [6:0] f7;
            rd = 5'($urandom);  rs1 = 5'($urandom);  rs2 = 5'($urandom);  f7 = 7'($urandom);
            rnd_word = rModel(f7, rs2, rs1, 3'b111, rd);
            applyStimulus(OP_R, rd, rs1, rs2, 3'b111, f7, $urandom, 1'b1, rnd_word, waited);
            idle();
            @(posedge clk); #1;
            checkOutput("wrap_flag", 32'(wrap), (i >= DEPTH - 1) ? 32'h1 : 32'h0);
            checkOutput("wrap_addr", 32'(mem_addr), 32'((i + 1) % DEPTH));
        end

        // Asynchronous reset mid-transfer aborts the pending word
        mem_ready = 1'b0;
        applyStimulus(OP_R, 2, 2, 2, 3'b000, 0, 32'h0, 1'b1, rModel(7'h00, 5'd2, 5'd2, 3'b000, 5'd2), waited);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        checkOutput("arst_we", 32'(mem_we), 32'h0);
        checkOutput("arst_addr", 32'(mem_addr), 32'h0);
        checkOutput("arst_wrap", 32'(wrap), 32'h0);
        checkOutput("arst_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("sb_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
